// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way select datapath.
package mux_pkg;

    // Default datapath width for the select stage.
    localparam int DEFAULT_WIDTH = 32;

    // Reasons a select error can be raised; only the range check is used today.
    localparam logic [1:0] SEL_ERR_NONE  = 2'd0;
    localparam logic [1:0] SEL_ERR_RANGE = 2'd1;
    localparam logic [1:0] SEL_ERR_MODE  = 2'd2;

    // Ceiling log2, never below 1 so a select port always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N_IN x WIDTH selector with an out-of-range flag.
module mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_IN  = 4,
    parameter int SEL_W = clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      data,
    output logic                  out_of_range
);

    logic [WIDTH-1:0] words [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Pick the addressed word; unused select codes yield zero.
    always_comb begin
        data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = words[k];
            end
        end
    end

    // Extra bit keeps the compare exact when N_IN is a power of two.
    assign out_of_range = ({1'b0, sel} >= (SEL_W + 1)'(N_IN));

endmodule

// File: rtl/mux_pipe_reg.sv
// N-way select feeding a pipeline stage register with stall, flush,
// valid tracking, stall counting and sticky select-error detection.
module mux_pipe_reg
    import mux_pkg::*;
#(
    parameter int              WIDTH      = DEFAULT_WIDTH,
    parameter int              N_IN       = 4,
    localparam int             SEL_W      = clog2(N_IN),
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int              CNT_W      = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [N_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]      Slc,
    input  logic                  InValid,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ErrClr,
    output logic [WIDTH-1:0]      Out,
    output logic                  OutValid,
    output logic [SEL_W-1:0]      SlcQ,
    output logic                  SelErr,
    output logic [CNT_W-1:0]      StallCnt
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic             load;

    logic [WIDTH-1:0] out_reg;
    logic             valid_reg;
    logic [SEL_W-1:0] slc_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;

    mux_n #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_data      (In),
        .sel          (Slc),
        .data         (sel_data),
        .out_of_range (sel_oor)
    );

    assign load = !Flush && !Stall;

    // Stage register: flush beats stall, stall beats load.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_reg   <= RESET_VAL;
            valid_reg <= 1'b0;
            slc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (Flush) begin
            out_reg   <= BUBBLE_VAL;
            valid_reg <= 1'b0;
            slc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (Stall) begin
            if (valid_reg && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            out_reg   <= sel_oor ? '0 : sel_data;
            valid_reg <= InValid;
            slc_reg   <= Slc;
            cnt_reg   <= '0;
        end
    end

    // Sticky select error; a new error outranks a simultaneous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_reg <= 1'b0;
        end else if (load && sel_oor && InValid) begin
            err_reg <= 1'b1;
        end else if (ErrClr) begin
            err_reg <= 1'b0;
        end
    end

    assign Out      = out_reg;
    assign OutValid = valid_reg;
    assign SlcQ     = slc_reg;
    assign SelErr   = err_reg;
    assign StallCnt = cnt_reg;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench: a 4-input instance (8-bit counter) and a 3-input
// instance (3-bit counter) share clock and reset.
module tb_mux_pipe_reg;

    localparam int W = 32;

    logic Clk = 1'b0;
    logic Rst;

    // 4-input instance
    logic [4*W-1:0] a_in;
    logic [1:0]     a_slc;
    logic           a_valid_in, a_stall, a_flush, a_errclr;
    logic [W-1:0]   a_out;
    logic           a_valid;
    logic [1:0]     a_slcq;
    logic           a_selerr;
    logic [7:0]     a_cnt;

    // 3-input instance
    logic [3*W-1:0] b_in;
    logic [1:0]     b_slc;
    logic           b_valid_in, b_stall, b_flush, b_errclr;
    logic [W-1:0]   b_out;
    logic           b_valid;
    logic [1:0]     b_slcq;
    logic           b_selerr;
    logic [2:0]     b_cnt;

    int checks = 0;
    int errors = 0;

    mux_pipe_reg #(.WIDTH(W), .N_IN(4), .CNT_W(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .In(a_in), .Slc(a_slc), .InValid(a_valid_in),
        .Stall(a_stall), .Flush(a_flush), .ErrClr(a_errclr),
        .Out(a_out), .OutValid(a_valid), .SlcQ(a_slcq), .SelErr(a_selerr),
        .StallCnt(a_cnt)
    );

    mux_pipe_reg #(.WIDTH(W), .N_IN(3), .CNT_W(3)) dut_b (
        .Clk(Clk), .Rst(Rst), .In(b_in), .Slc(b_slc), .InValid(b_valid_in),
        .Stall(b_stall), .Flush(b_flush), .ErrClr(b_errclr),
        .Out(b_out), .OutValid(b_valid), .SlcQ(b_slcq), .SelErr(b_selerr),
        .StallCnt(b_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
        $display("t=%0t a_out=%h a_v=%0b a_cnt=%0d | b_out=%h b_v=%0b b_err=%0b b_cnt=%0d",
                 $time, a_out, a_valid, a_cnt, b_out, b_valid, b_selerr, b_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        a_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_slc = 2'd0; a_valid_in = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_errclr = 1'b0;
        b_in = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        b_slc = 2'd0; b_valid_in = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_errclr = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        check("rst_out", a_out, 32'h0);
        check("rst_valid", W'(a_valid), 32'h0);
        check("rst_slcq", W'(a_slcq), 32'h0);
        check("rst_cnt", W'(a_cnt), 32'h0);
        check("rst_selerr", W'(a_selerr), 32'h0);

        // Load sweep across all four inputs
        a_valid_in = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_slc = 2'(s);
            tick();
            check("sweep_out", a_out, 32'h11111111 * (s + 1));
            check("sweep_valid", W'(a_valid), 32'h1);
            check("sweep_slcq", W'(a_slcq), W'(s));
        end

        // Stall for five edges while inputs change
        a_slc = 2'd1;
        tick();
        check("pre_stall_out", a_out, 32'h22222222);
        a_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = {4{32'hDEAD0000 + 32'(i)}};
            a_slc = 2'(i);
            tick();
        end
        check("stall_out", a_out, 32'h22222222);
        check("stall_slcq", W'(a_slcq), 32'h1);
        check("stall_cnt", W'(a_cnt), 32'd5);
        a_stall = 1'b0;
        a_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_slc = 2'd3;
        tick();
        check("unstall_out", a_out, 32'h44444444);
        check("unstall_cnt", W'(a_cnt), 32'h0);

        // Flush together with stall, after a couple of stalled edges
        a_stall = 1'b1;
        tick();
        tick();
        check("pre_flush_cnt", W'(a_cnt), 32'd2);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("flush_out", a_out, 32'h0);
        check("flush_valid", W'(a_valid), 32'h0);
        check("flush_cnt", W'(a_cnt), 32'h0);
        check("flush_slcq", W'(a_slcq), 32'h0);
        tick();
        tick();
        check("stall_invalid_cnt", W'(a_cnt), 32'h0);
        a_stall = 1'b0;

        // Invalid load still latches the payload
        a_valid_in = 1'b0;
        a_slc = 2'd2;
        tick();
        check("inv_load_out", a_out, 32'h33333333);
        check("inv_load_valid", W'(a_valid), 32'h0);

        // Asynchronous reset in the middle of a stall
        a_valid_in = 1'b1;
        a_slc = 2'd0;
        tick();
        a_stall = 1'b1;
        tick();
        tick();
        check("pre_arst_cnt", W'(a_cnt), 32'd2);
        #2 Rst = 1'b1;
        #1;
        check("arst_out", a_out, 32'h0);
        check("arst_valid", W'(a_valid), 32'h0);
        check("arst_cnt", W'(a_cnt), 32'h0);
        #1 Rst = 1'b0;
        a_stall = 1'b0;

        // Counter saturation with a 3-bit counter
        b_valid_in = 1'b1;
        b_slc = 2'd0;
        tick();
        check("b_load_out", b_out, 32'hAAAAAAAA);
        b_stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("sat_cnt", W'(b_cnt), 32'd7);
        check("sat_out", b_out, 32'hAAAAAAAA);
        b_stall = 1'b0;

        // Out-of-range select on a 3-input instance
        b_slc = 2'd3;
        tick();
        check("oor_out", b_out, 32'h0);
        check("oor_selerr", W'(b_selerr), 32'h1);
        check("oor_valid", W'(b_valid), 32'h1);
        check("oor_slcq", W'(b_slcq), 32'd3);
        b_slc = 2'd1;
        tick();
        check("good_after_err_out", b_out, 32'hBBBBBBBB);
        check("err_sticky", W'(b_selerr), 32'h1);
        b_errclr = 1'b1;
        b_slc = 2'd3;
        tick();
        check("set_beats_clr", W'(b_selerr), 32'h1);
        b_slc = 2'd2;
        tick();
        b_errclr = 1'b0;
        check("clr_selerr", W'(b_selerr), 32'h0);
        check("clr_out", b_out, 32'hCCCCCCCC);
        b_valid_in = 1'b0;
        b_slc = 2'd3;
        tick();
        check("oor_invalid_selerr", W'(b_selerr), 32'h0);
        check("oor_invalid_out", b_out, 32'h0);
        b_valid_in = 1'b1;
        tick();
        check("reset_err_again", W'(b_selerr), 32'h1);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        check("flush_keeps_selerr", W'(b_selerr), 32'h1);
        check("b_flush_valid", W'(b_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_reg.md
Name: mux_pipe_reg

Overview:
- Parametrised N-way, WIDTH-bit select feeding a pipeline stage register with stall, flush, valid tracking and select-error detection.
- Successor to the combinational 2:1 datapath mux: same selection role, generalised in width and input count, now registered.
- Used at pipeline-stage boundaries (forwarding / writeback / PC-source selection into the next stage latch) so selection and latching happen in one block.

Parameters:
- WIDTH, 32, data width of each input and of Out
- N_IN, 4, number of data inputs (2..16)
- SEL_W, clog2(N_IN) (min 1), select width; derived, not overridden
- RESET_VAL, 0, value Out takes on reset
- BUBBLE_VAL, 0, value Out takes on flush
- CNT_W, 8, width of saturating stall counter

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- In  in  N_IN*WIDTH  flattened data inputs; input k = In[k*WIDTH +: WIDTH]
- Slc  in  SEL_W  input select
- InValid  in  1  upstream stage holds a valid instruction
- Stall  in  1  hold register contents this cycle
- Flush  in  1  insert bubble this cycle
- ErrClr  in  1  clear sticky select error
- Out  out  WIDTH  registered selected data
- OutValid  out  1  Out holds a valid instruction's data
- SlcQ  out  SEL_W  select value latched with Out
- SelErr  out  1  sticky: out-of-range select was latched
- StallCnt  out  CNT_W  consecutive stalled cycles while OutValid, saturating

Behaviour:
- Reset: asynchronous and active-high; Rst=1 forces Out=RESET_VAL, OutValid=0, SlcQ=0, SelErr=0, StallCnt=0 immediately, independent of Clk. Reset mid-stall discards held data and the count.
- Latency: 1 cycle. Values selected at edge n appear on Out after edge n.
- Priority per rising edge: Rst > Flush > Stall > Load.
- Flush (wins over Stall when both are asserted): Out=BUBBLE_VAL, OutValid=0, SlcQ=0, StallCnt=0. SelErr is unchanged.
- Stall (Flush=0): Out, OutValid and SlcQ hold.
  - StallCnt increments by 1 if OutValid=1, saturating at 2^CNT_W-1.
  - StallCnt holds at 0 if OutValid=0.
- Load (Flush=0, Stall=0): SlcQ=Slc, OutValid=InValid, StallCnt=0.
  - Slc<N_IN: Out=In[Slc].
  - Slc>=N_IN (only possible when N_IN is not a power of 2): Out=0. If InValid=1, set SelErr. If InValid=0, SelErr is not set.
- SelErr sticky: set by an invalid valid load; cleared by ErrClr=1 at an edge. If a set and ErrClr occur in the same edge, set wins.
- InValid=0 loads still latch data (don't-care payload) but OutValid=0.
- No combinational path from any input to any output.

Decomposition:
- Shared package mux_pkg:
  - clog2 constant function (min result 1)
  - default WIDTH constant
  - sel_err reason constants for future modes
- One sub-module, mux_n: combinational parametrised N_IN x WIDTH selector with out-of-range flag output.
- mux_pipe_reg instantiates mux_n plus the register / control logic.

Test Plan:
- Reset: drive Out non-zero, assert Rst between edges → Out=0, OutValid=0, StallCnt=0 before the next edge.
- Load sweep, N_IN=4: In0..In3=0x11111111,0x22222222,0x33333333,0x44444444, InValid=1, Slc=0..3 on successive edges → Out follows one cycle later with OutValid=1 and SlcQ matching.
- Stall: load 0x22222222, hold Stall=1 for 5 edges while In changes → Out stays 0x22222222, StallCnt=5. Deassert Stall → next load, StallCnt=0.
- Saturation, CNT_W=3: Stall 10 edges with OutValid=1 → StallCnt=7.
- Flush+Stall same edge → Out=BUBBLE_VAL(0), OutValid=0, StallCnt=0.
- N_IN=3, Slc=3:
  - InValid=1 → Out=0, SelErr=1, stays 1 on later good loads.
  - ErrClr=1 with a simultaneous Slc=3 valid load → SelErr stays 1.
  - ErrClr alone → SelErr=0.
